led_counter_bank: RTL
=====================

Name: led_counter_bank

Overview:
- Parametrised successor to the fixed eight-counter LED blink bank.
- Holds CHANNELS independent counters in the clk_1 domain. Each counter has its own enable; one global mode (up, down, bounce or hold) applies to all.
- Each channel drives one LED from a selectable tap.
- A lockstep checker compares every channel against channel 0 and latches sticky per-channel errors. Fault injection exercises the checker on silicon.

Parameters:
- CHANNELS, 8, number of counter channels (2..16)
- BITS, 8, upper counter bits above the delay field
- LOG2DELAY, 21, low bits below the LED tap; counter width W = BITS+LOG2DELAY

Ports:
- clk_1  in  1  clock for all state
- rst  in  1  reset, synchronous, active-low
- en  in  CHANNELS  per-channel count enable
- mode  in  2  global mode: 0 up, 1 down, 2 bounce, 3 hold
- sync  in  1  synchronous realign: zero all counters, clear errors
- inject  in  CHANNELS  fault injection: double step on that channel this cycle
- led  out  CHANNELS  led[i] = cnt_i[LOG2DELAY]
- err_ch  out  CHANNELS  sticky lockstep error per channel; bit 0 always 0
- mismatch  out  1  registered OR of err_ch

Behaviour:
- Priority at each clk_1 edge: rst low > sync high > normal operation.
- On rst low, and on sync high:
  - every cnt_i = 0, dir_i = up, aligned_i = 1;
  - err_ch = 0, mismatch = 0, so led = 0.
- Normal operation, channel i with en_i = 0: cnt_i and dir_i hold.
- Normal operation, channel i with en_i = 1:
  - mode 0 (up): cnt_i += (inject_i ? 2 : 1), mod 2^W.
  - mode 1 (down): cnt_i -= (inject_i ? 2 : 1), mod 2^W.
  - mode 2 (bounce), dir up: if cnt_i == 2^W-1 then cnt_i <= 2^W-2 and dir_i <= down, else cnt_i += 1.
  - mode 2 (bounce), dir down: if cnt_i == 0 then cnt_i <= 1 and dir_i <= up, else cnt_i -= 1.
  - mode 2 ignores inject_i.
  - mode 3 (hold): cnt_i holds; inject_i ignored.
- dir_i is forced to up on any cycle where mode != 2. Switching into bounce therefore always starts upward.
- Mode changes take effect at the next edge. There is no pipeline, and counters update in the same edge as the mode sample.
- Alignment tracking:
  - aligned_i is cleared at the edge where en_i != en_0.
  - It is set again only by rst or sync.
  - aligned_0 is always 1.
- Checker, for i >= 1:
  - If aligned_i == 1 and the registered cnt_i != cnt_0, err_ch[i] <= 1.
  - Latency: a divergence created at edge k is flagged at edge k+1.
  - err_ch[i] stays set until rst or sync.
- mismatch is the OR of err_ch, registered one further cycle, so it rises at edge k+2.
- led is taken directly from the counter register; there is no extra flop.
- A sync held high for multiple cycles keeps the block in the cleared state. Counting resumes on the first edge after sync falls.

Decomposition:
- Shared package: mode encoding constants (MODE_UP = 0, MODE_DOWN = 1, MODE_BOUNCE = 2, MODE_HOLD = 3) and a width function W(BITS, LOG2DELAY).
- One sub-module, led_counter_chan, holds cnt, dir, the step/inject logic and the led tap. It is generated CHANNELS times.
- The alignment tracking and checker stay in the top level.

Test Plan (BITS = 2, LOG2DELAY = 2, W = 4, CHANNELS = 4):
- Reset, then en = 4'hF, mode = 0 for 5 cycles → every cnt = 5 and led = 4'hF. After 12 more cycles every cnt = 1 (wraps 15→0) and led = 0. err_ch = 0 throughout.
- From reset, mode = 2 for 20 cycles → cnt sequence 0,1,…,15,14,13,12,11. After the 15th edge (cnt = 15) the dir flips down. led follows cnt[2].
- From reset, mode = 1 for 1 cycle → cnt = 15 on all channels. Then mode = 3 for 4 cycles → cnt stays 15.
- Counting up, pulse inject = 4'b0100 for one cycle at edge k → cnt_2 is one ahead of cnt_0. err_ch = 4'b0100 at edge k+1 and mismatch = 1 at edge k+2. Both persist until a sync pulse, after which cnt = 0, err_ch = 0 and mismatch = 0.
- Drop en[1] for 3 cycles, then restore → aligned_1 cleared, err_ch[1] stays 0 despite cnt_1 lagging by 3. A sync realigns; a later inject[1] then sets err_ch[1].
- Assert rst low while mode = 2 and dir = down (cnt = 10) → next edge: cnt = 0, err_ch = 0. First edge after release with mode = 2: cnt = 1, counting up.

Source files
------------

// File: rtl/led_counter_bank_pkg.sv
// Shared definitions for the LED counter bank: mode encoding and counter width.
package led_counter_bank_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  function automatic int cnt_w(input int bits, input int log2delay);
    return bits + log2delay;
  endfunction

endpackage

// File: rtl/led_counter_bank_chan.sv
// One counter channel: up/down/bounce/hold stepping with fault-injection double step.
module led_counter_chan
  import led_counter_bank_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int LOG2DELAY = 21,
  parameter int W         = cnt_w(BITS, LOG2DELAY)
) (
  input  logic         clk_1,
  input  logic         rst,
  input  logic         sync,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         inject,
  output logic [W-1:0] cnt,
  output logic         led
);

  logic [W-1:0] r_cnt;
  logic         r_dir;   // 0 = up, 1 = down; only meaningful in bounce mode
  logic [W-1:0] w_step;

  assign w_step = {{(W-2){1'b0}}, inject, ~inject};

  always_ff @(posedge clk_1) begin
    if (!rst || sync) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else begin
      // Leaving bounce mode always resets the direction so re-entry starts upward
      if (mode != MODE_BOUNCE) r_dir <= 1'b0;
      if (en) begin
        case (mode)
          MODE_UP:   r_cnt <= r_cnt + w_step;
          MODE_DOWN: r_cnt <= r_cnt - w_step;
          MODE_BOUNCE: begin
            if (!r_dir) begin
              if (r_cnt == '1) begin
                r_cnt <= '1 - {{(W-1){1'b0}}, 1'b1};
                r_dir <= 1'b1;
              end else begin
                r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
              end
            end else begin
              if (r_cnt == '0) begin
                r_cnt <= {{(W-1){1'b0}}, 1'b1};
                r_dir <= 1'b0;
              end else begin
                r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
              end
            end
          end
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  assign cnt = r_cnt;
  assign led = r_cnt[LOG2DELAY];

endmodule

// File: rtl/led_counter_bank.sv
// Bank of CHANNELS blink counters with a lockstep checker against channel 0.
module led_counter_bank
  import led_counter_bank_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int BITS      = 8,
  parameter int LOG2DELAY = 21
) (
  input  logic                clk_1,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic [1:0]          mode,
  input  logic                sync,
  input  logic [CHANNELS-1:0] inject,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] err_ch,
  output logic                mismatch
);

  localparam int W = cnt_w(BITS, LOG2DELAY);

  logic [W-1:0]        w_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_aligned;
  logic [CHANNELS-1:0] r_err;
  logic                r_mismatch;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_counter_chan #(
      .BITS      (BITS),
      .LOG2DELAY (LOG2DELAY),
      .W         (W)
    ) u_chan (
      .clk_1  (clk_1),
      .rst    (rst),
      .sync   (sync),
      .en     (en[g]),
      .mode   (mode),
      .inject (inject[g]),
      .cnt    (w_cnt[g]),
      .led    (led[g])
    );
  end

  // Checker works on registered counts, so a divergence shows up one edge later
  always_ff @(posedge clk_1) begin
    if (!rst || sync) begin
      r_aligned  <= '1;
      r_err      <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= |r_err;
      for (int i = 1; i < CHANNELS; i++) begin
        if (en[i] != en[0]) r_aligned[i] <= 1'b0;
        if (r_aligned[i] && (w_cnt[i] != w_cnt[0])) r_err[i] <= 1'b1;
      end
    end
  end

  assign err_ch   = r_err;
  assign mismatch = r_mismatch;

endmodule
